noc_local_ni: RTL and testbench

- Network interface at a NoC router's Local port; it is the endpoint side of that port's write/full/almost_full protocol.
- TX path: packs core requests into 16-bit flits and injects them into the router's local input FIFO, honouring full and almost_full.
- RX path: buffers flits ejected by the router's Local output in a small FIFO, drives full/almost_full back to the router, and delivers the flits to the core with valid/ready.
- Flit format: [0] valid, [2:1] destination IP, [15:3] payload (13 bits).

---
 rtl/noc_local_ni.sv | 167 ++++++++++++++++
 tb/tb_noc_local_ni.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_local_ni.sv
`default_nettype none
// ============================================================================
// Module   : noc_local_ni
// Brief    : NoC Local-port network interface. A single-entry TX hold stage
//            injects flits into the router. An RX FIFO buffers ejected flits.
//            Optional ejection destination check: NOC_NI_DSTCHK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module noc_local_ni #(
    parameter logic [1:0] LOCAL_IP  = 2'b00,
    parameter int         RX_DEPTH  = 8,
    parameter int         AF_MARGIN = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        tx_valid,
    input  logic [1:0]                  tx_dst,
    input  logic [12:0]                 tx_payload,
    output logic                        tx_ready,
    output logic [15:0]                 inj_data,
    output logic                        inj_write,
    input  logic                        inj_full,
    input  logic                        inj_almost_full,
    input  logic [15:0]                 ej_data,
    input  logic                        ej_write,
    output logic                        ej_full,
    output logic                        ej_almost_full,
    output logic                        rx_valid,
    output logic [1:0]                  rx_dst,
    output logic [12:0]                 rx_payload,
    input  logic                        rx_ready,
    output logic [$clog2(RX_DEPTH):0]   rx_count,
    output logic                        rx_overflow,
    output logic                        rx_misroute
);

    localparam int              c_AW       = $clog2(RX_DEPTH);
    localparam logic [c_AW:0]   c_DEPTH    = (c_AW + 1)'(RX_DEPTH);
    localparam logic [c_AW:0]   c_AF_LEVEL = (c_AW + 1)'(RX_DEPTH - AF_MARGIN);

    localparam logic [0:0]      T_IDLE     = 1'b0;
    localparam logic [0:0]      T_HOLD     = 1'b1;

    logic [0:0]     r_state;
    logic [0:0]     w_nextState;
    logic           r_injOk;
    logic [1:0]     r_holdDst;
    logic [12:0]    r_holdPayload;
    logic           w_sendNow;
    logic           w_txReady;
    logic           w_accept;

    // ---------------- TX FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= T_IDLE;
        else       r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            T_IDLE:  if (w_accept) w_nextState = T_HOLD;
            T_HOLD:  if (w_sendNow && !w_accept) w_nextState = T_IDLE;
            default: w_nextState = T_IDLE;
        endcase
    end

    // tx_ready is masked by reset so the core never sees a handshake while reset is held
    always_comb begin
        w_sendNow = (r_state == T_HOLD) && r_injOk;
        w_txReady = !reset && ((r_state == T_IDLE) || w_sendNow);
    end

    assign tx_ready = w_txReady;
    assign w_accept = tx_valid && w_txReady;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_injOk       <= 1'b0;
            inj_write     <= 1'b0;
            inj_data      <= '0;
            r_holdDst     <= '0;
            r_holdPayload <= '0;
        end else begin
            r_injOk <= !((inj_almost_full & inj_write) | inj_full);
            if (w_sendNow) begin
                inj_write <= 1'b1;
                inj_data  <= {r_holdPayload, r_holdDst, 1'b1};
            end else begin
                inj_write <= 1'b0;
                inj_data  <= '0;
            end
            if (w_accept) begin
                r_holdDst     <= tx_dst;
                r_holdPayload <= tx_payload;
            end
        end
    end

    // ---------------- RX FIFO ----------------
    // The always-set valid bit is not stored: entries hold {payload, dst}.
    logic [14:0]        r_mem [RX_DEPTH];
    logic [c_AW-1:0]    r_wrPtr;
    logic [c_AW-1:0]    r_rdPtr;
    logic [c_AW:0]      r_count;
    logic               r_overflow;
    logic               w_ejValid;
    logic               w_rxFull;
    logic               w_dstOk;
    logic               w_push;
    logic               w_pop;
    logic [14:0]        w_head;

    assign w_ejValid = ej_write && ej_data[0];
    assign w_rxFull  = (r_count == c_DEPTH);
    assign w_push    = w_ejValid && !w_rxFull && w_dstOk;
    assign w_pop     = rx_valid && rx_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RX_DEPTH; i++) r_mem[i] <= '0;
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wrPtr] <= ej_data[15:1];
                r_wrPtr        <= r_wrPtr + 1'b1;
            end
            if (w_pop) r_rdPtr <= r_rdPtr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // a same-cycle pop does not make room: fullness is judged on the registered count
            if (w_ejValid && w_rxFull) r_overflow <= 1'b1;
        end
    end

`ifdef NOC_NI_DSTCHK_EN
    logic r_misroute;
    assign w_dstOk = (ej_data[2:1] == LOCAL_IP);
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                   r_misroute <= 1'b0;
        else if (w_ejValid && !w_rxFull && !w_dstOk) r_misroute <= 1'b1;
    end
    assign rx_misroute = r_misroute;
`else
    logic w_unusedLocalIp;
    assign w_unusedLocalIp = ^LOCAL_IP;
    assign w_dstOk         = 1'b1;
    assign rx_misroute     = 1'b0;
`endif

    assign w_head         = r_mem[r_rdPtr];
    assign ej_full        = w_rxFull;
    assign ej_almost_full = (r_count >= c_AF_LEVEL);
    assign rx_valid       = (r_count != '0);
    assign rx_dst         = w_head[1:0];
    assign rx_payload     = w_head[14:2];
    assign rx_count       = r_count;
    assign rx_overflow    = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_noc_local_ni.sv
`default_nettype none
// ============================================================================
// Module   : tb_noc_local_ni
// Brief    : Self-checking bench for noc_local_ni using a queue-based reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_noc_local_ni;

    localparam logic [1:0] LIP = 2'b01;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        tx_valid = 1'b0;
    logic [1:0]  tx_dst = '0;
    logic [12:0] tx_payload = '0;
    logic        tx_ready;
    logic [15:0] inj_data;
    logic        inj_write;
    logic        inj_full = 1'b0;
    logic        inj_almost_full = 1'b0;
    logic [15:0] ej_data = '0;
    logic        ej_write = 1'b0;
    logic        ej_full;
    logic        ej_almost_full;
    logic        rx_valid;
    logic [1:0]  rx_dst;
    logic [12:0] rx_payload;
    logic        rx_ready = 1'b0;
    logic [3:0]  rx_count;
    logic        rx_overflow;
    logic        rx_misroute;

    int          nVec = 0;
    int          nFail = 0;

    logic [14:0] rxQ[$];
    logic [15:0] txQ[$];
    logic        expOvf = 1'b0;
    logic        expMis = 1'b0;
    logic        blockedCur = 1'b0;
    logic        blockedPrev = 1'b0;

    noc_local_ni #(.LOCAL_IP(LIP), .RX_DEPTH(8), .AF_MARGIN(2)) dut (
        .clk(clk), .reset(reset),
        .tx_valid(tx_valid), .tx_dst(tx_dst), .tx_payload(tx_payload), .tx_ready(tx_ready),
        .inj_data(inj_data), .inj_write(inj_write),
        .inj_full(inj_full), .inj_almost_full(inj_almost_full),
        .ej_data(ej_data), .ej_write(ej_write),
        .ej_full(ej_full), .ej_almost_full(ej_almost_full),
        .rx_valid(rx_valid), .rx_dst(rx_dst), .rx_payload(rx_payload), .rx_ready(rx_ready),
        .rx_count(rx_count), .rx_overflow(rx_overflow), .rx_misroute(rx_misroute)
    );

    always #5 clk = ~clk;

    // One clock: samples pre-edge handshakes, then advances the reference model.
    task automatic tick();
        logic preReady;
        logic preBlocked;
        logic dstOk;
        int   pre;
        #2;
        preReady   = tx_ready;
        preBlocked = inj_full | (inj_almost_full & inj_write);
        pre        = rxQ.size();
        @(posedge clk);
        #1;
        if (tx_valid && preReady) txQ.push_back({tx_payload, tx_dst, 1'b1});
        blockedPrev = blockedCur;
        blockedCur  = preBlocked;
        dstOk = 1'b1;
`ifdef NOC_NI_DSTCHK_EN
        dstOk = (ej_data[2:1] == LIP);
`endif
        if (pre > 0 && rx_ready) void'(rxQ.pop_front());
        if (ej_write && ej_data[0]) begin
            if (pre == 8)    expOvf = 1'b1;
            else if (!dstOk) expMis = 1'b1;
            else             rxQ.push_back(ej_data[15:1]);
        end
    endtask

    task automatic do_reset();
        tx_valid = 0; ej_write = 0; ej_data = '0; rx_ready = 0;
        inj_full = 0; inj_almost_full = 0;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        rxQ.delete(); txQ.delete();
        expOvf = 0; expMis = 0; blockedCur = 0; blockedPrev = 0;
        tick();
    endtask

    task automatic test_reset();
        nVec++; if (tx_ready !== 1'b0) begin nFail++; $display("FAIL reset_tx_ready: got %b want 0", tx_ready); end
        nVec++; if ({inj_write, inj_data} !== 17'h0) begin nFail++; $display("FAIL reset_inj: got %h want 0", {inj_write, inj_data}); end
        nVec++; if ({ej_full, ej_almost_full, rx_valid, rx_overflow, rx_misroute} !== 5'b0) begin
            nFail++; $display("FAIL reset_flags: got %b want 00000", {ej_full, ej_almost_full, rx_valid, rx_overflow, rx_misroute}); end
        nVec++; if ({rx_dst, rx_payload} !== 15'h0) begin nFail++; $display("FAIL reset_head: got %h want 0", {rx_payload, rx_dst}); end
        nVec++; if (rx_count !== 4'd0) begin nFail++; $display("FAIL reset_count: got %0d want 0", rx_count); end
        tx_valid = 1'b1;
        #1;
        nVec++; if (tx_ready !== 1'b0) begin nFail++; $display("FAIL reset_tx_ready_valid: got %b want 0", tx_ready); end
        tx_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        nVec++; if (tx_ready !== 1'b1) begin nFail++; $display("FAIL post_reset_tx_ready: got %b want 1", tx_ready); end
        tick();
    endtask

    task automatic test_single_tx();
        int nW = 0;
        do_reset();
        tx_valid = 1; tx_dst = 2'b10; tx_payload = 13'h0ABC;
        tick();
        tx_valid = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (inj_write) begin
                nW++;
                nVec++; if (inj_data !== 16'h55E5) begin nFail++; $display("FAIL single_data: got %h want 55e5", inj_data); end
            end
        end
        nVec++; if (nW !== 1) begin nFail++; $display("FAIL single_pulses: got %0d want 1", nW); end
        nVec++; if (inj_data !== 16'h0) begin nFail++; $display("FAIL single_idle_data: got %h want 0", inj_data); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] f [4];
        int got = 0;
        int first = -1;
        do_reset();
        for (int i = 0; i < 4; i++) f[i] = {13'($urandom), 2'($urandom), 1'b1};
        for (int c = 0; c < 10; c++) begin
            if (c < 4) begin
                tx_valid = 1; tx_dst = f[c][2:1]; tx_payload = f[c][15:3];
                #1;
                nVec++; if (tx_ready !== 1'b1) begin nFail++; $display("FAIL b2b_ready[%0d]: got %b want 1", c, tx_ready); end
            end else begin
                tx_valid = 0;
            end
            tick();
            if (inj_write) begin
                if (first < 0) first = c;
                nVec++; if (c !== first + got) begin nFail++; $display("FAIL b2b_gap: write at %0d want %0d", c, first + got); end
                if (got < 4) begin
                    nVec++; if (inj_data !== f[got]) begin nFail++; $display("FAIL b2b_data[%0d]: got %h want %h", got, inj_data, f[got]); end
                end
                got++;
            end
        end
        nVec++; if (got !== 4) begin nFail++; $display("FAIL b2b_count: got %0d want 4", got); end
        nVec++; if (first !== 1) begin nFail++; $display("FAIL b2b_latency: first write at %0d want 1", first); end
    endtask

    task automatic test_tx_backpressure();
        logic [15:0] a;
        logic [15:0] b;
        do_reset();
        a = {13'($urandom), 2'($urandom), 1'b1};
        b = {13'($urandom), 2'($urandom), 1'b1};
        inj_full = 1;
        tick();
        tx_valid = 1; tx_dst = a[2:1]; tx_payload = a[15:3];
        #1;
        nVec++; if (tx_ready !== 1'b1) begin nFail++; $display("FAIL bp_first_accept: got %b want 1", tx_ready); end
        tick();
        tx_dst = b[2:1]; tx_payload = b[15:3];
        for (int c = 0; c < 4; c++) begin
            #1;
            nVec++; if (tx_ready !== 1'b0) begin nFail++; $display("FAIL bp_ready[%0d]: got %b want 0", c, tx_ready); end
            tick();
            nVec++; if (inj_write !== 1'b0) begin nFail++; $display("FAIL bp_write[%0d]: got %b want 0", c, inj_write); end
        end
        inj_full = 0;
        tick();
        nVec++; if (inj_write !== 1'b0) begin nFail++; $display("FAIL bp_release1: got %b want 0", inj_write); end
        #1;
        nVec++; if (tx_ready !== 1'b1) begin nFail++; $display("FAIL bp_release_ready: got %b want 1", tx_ready); end
        tick();
        tx_valid = 0;
        nVec++; if ({inj_write, inj_data} !== {1'b1, a}) begin nFail++; $display("FAIL bp_flit_a: got %b/%h want 1/%h", inj_write, inj_data, a); end
        tick();
        nVec++; if ({inj_write, inj_data} !== {1'b1, b}) begin nFail++; $display("FAIL bp_flit_b: got %b/%h want 1/%h", inj_write, inj_data, b); end
        tick();
        nVec++; if (inj_write !== 1'b0) begin nFail++; $display("FAIL bp_no_dup: got %b want 0", inj_write); end
    endtask

    task automatic test_rx_fill();
        logic [12:0] p [9];
        int n;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            p[i] = 13'($urandom);
            ej_write = 1; ej_data = {p[i], LIP, 1'b1};
            tick();
            n = i + 1;
            nVec++; if (rx_count !== ((n > 8) ? 4'd8 : 4'(n))) begin nFail++; $display("FAIL fill_count[%0d]: got %0d", n, rx_count); end
            nVec++; if (ej_almost_full !== (n >= 6)) begin nFail++; $display("FAIL fill_af[%0d]: got %b want %b", n, ej_almost_full, n >= 6); end
            nVec++; if (ej_full !== (n >= 8)) begin nFail++; $display("FAIL fill_full[%0d]: got %b want %b", n, ej_full, n >= 8); end
            nVec++; if (rx_overflow !== (n >= 9)) begin nFail++; $display("FAIL fill_ovf[%0d]: got %b want %b", n, rx_overflow, n >= 9); end
        end
        ej_write = 0; rx_ready = 1;
        for (int i = 0; i < 8; i++) begin
            nVec++; if ({rx_payload, rx_dst} !== {p[i], LIP}) begin nFail++; $display("FAIL fill_drain[%0d]: got %h want %h", i, {rx_payload, rx_dst}, {p[i], LIP}); end
            tick();
        end
        rx_ready = 0;
        nVec++; if ({rx_valid, rx_overflow} !== 2'b01) begin nFail++; $display("FAIL fill_after_drain: got %b want 01", {rx_valid, rx_overflow}); end
    endtask

    task automatic test_rx_concurrency();
        logic [12:0] p [5];
        logic [12:0] order [3];
        do_reset();
        for (int i = 0; i < 5; i++) p[i] = 13'($urandom);
        ej_write = 1;
        ej_data = {p[0], LIP, 1'b1}; tick();
        ej_data = {p[4], LIP, 1'b0}; tick();
        ej_data = {p[1], LIP, 1'b1}; tick();
        ej_data = {p[2], LIP, 1'b1}; tick();
        nVec++; if (rx_count !== 4'd3) begin nFail++; $display("FAIL conc_count: got %0d want 3", rx_count); end
        ej_data = {p[3], LIP, 1'b1}; rx_ready = 1;
        tick();
        ej_write = 0;
        nVec++; if (rx_count !== 4'd3) begin nFail++; $display("FAIL conc_pushpop: got %0d want 3", rx_count); end
        order[0] = p[1]; order[1] = p[2]; order[2] = p[3];
        for (int i = 0; i < 3; i++) begin
            nVec++; if (rx_payload !== order[i]) begin nFail++; $display("FAIL conc_order[%0d]: got %h want %h", i, rx_payload, order[i]); end
            tick();
        end
        rx_ready = 0;
        nVec++; if (rx_valid !== 1'b0) begin nFail++; $display("FAIL conc_empty: got %b want 0", rx_valid); end
    endtask

    task automatic test_dstchk();
        logic [3:0] expCount;
        logic       expFlag;
        do_reset();
        ej_write = 1;
        for (int i = 0; i < 2; i++) begin
            ej_data = {13'($urandom), LIP, 1'b1};
            tick();
        end
        ej_data = {13'($urandom), 2'b11, 1'b1};
        tick();
        ej_write = 0;
`ifdef NOC_NI_DSTCHK_EN
        expCount = 4'd2; expFlag = 1'b1;
`else
        expCount = 4'd3; expFlag = 1'b0;
`endif
        nVec++; if (rx_count !== expCount) begin nFail++; $display("FAIL dst_count: got %0d want %0d", rx_count, expCount); end
        nVec++; if (rx_misroute !== expFlag) begin nFail++; $display("FAIL dst_flag: got %b want %b", rx_misroute, expFlag); end
    endtask

    task automatic test_async_reset();
        do_reset();
        ej_write = 1;
        for (int i = 0; i < 5; i++) begin
            ej_data = {13'($urandom), LIP, 1'b1};
            if (i == 3) inj_full = 1;
            if (i == 4) begin tx_valid = 1; tx_dst = 2'($urandom); tx_payload = 13'($urandom); end
            tick();
        end
        ej_write = 0; tx_valid = 0;
        nVec++; if (rx_count !== 4'd5) begin nFail++; $display("FAIL areset_pre_count: got %0d want 5", rx_count); end
        #1;
        reset = 1;
        #1;
        nVec++; if ({tx_ready, inj_write, inj_data} !== 18'h0) begin nFail++; $display("FAIL areset_tx: got %h want 0", {tx_ready, inj_write, inj_data}); end
        nVec++; if ({ej_full, ej_almost_full, rx_valid, rx_overflow, rx_misroute, rx_count} !== 9'h0) begin
            nFail++; $display("FAIL areset_rx: got %h want 0", {ej_full, ej_almost_full, rx_valid, rx_overflow, rx_misroute, rx_count}); end
        nVec++; if ({rx_dst, rx_payload} !== 15'h0) begin nFail++; $display("FAIL areset_head: got %h want 0", {rx_payload, rx_dst}); end
        reset = 0;
        inj_full = 0;
        rxQ.delete(); txQ.delete(); expOvf = 0; expMis = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            nVec++; if ({inj_write, rx_count} !== 5'h0) begin nFail++; $display("FAIL areset_after[%0d]: got %h want 0", c, {inj_write, rx_count}); end
        end
    endtask

    task automatic test_random();
        int size;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            tx_valid        = ($urandom_range(0, 9) < 7);
            tx_dst          = 2'($urandom);
            tx_payload      = 13'($urandom);
            inj_full        = ($urandom_range(0, 4) == 0);
            inj_almost_full = ($urandom_range(0, 2) == 0);
            ej_write        = ($urandom_range(0, 1) == 1);
            ej_data         = {13'($urandom), ($urandom_range(0, 4) == 0) ? 2'($urandom) : LIP,
                               ($urandom_range(0, 3) != 0)};
            rx_ready        = ($urandom_range(0, 2) == 0);
            tick();
            size = rxQ.size();
            nVec++; if (rx_count !== 4'(size)) begin nFail++; $display("FAIL rnd_count@%0d: got %0d want %0d", c, rx_count, size); end
            nVec++; if ({rx_valid, ej_almost_full, ej_full} !== {size != 0, size >= 6, size == 8}) begin
                nFail++; $display("FAIL rnd_status@%0d: got %b want %b", c, {rx_valid, ej_almost_full, ej_full}, {size != 0, size >= 6, size == 8}); end
            if (size > 0) begin
                nVec++; if ({rx_payload, rx_dst} !== rxQ[0]) begin nFail++; $display("FAIL rnd_head@%0d: got %h want %h", c, {rx_payload, rx_dst}, rxQ[0]); end
            end
            nVec++; if ({rx_overflow, rx_misroute} !== {expOvf, expMis}) begin
                nFail++; $display("FAIL rnd_sticky@%0d: got %b want %b", c, {rx_overflow, rx_misroute}, {expOvf, expMis}); end
            if (inj_write) begin
                nVec++; if (blockedPrev) begin nFail++; $display("FAIL rnd_backpressure@%0d: write %b while blocked", c, inj_write); end
                if (txQ.size() == 0) begin
                    nVec++; nFail++; $display("FAIL rnd_extra_flit@%0d: got %h want none", c, inj_data);
                end else begin
                    nVec++; if (inj_data !== txQ[0]) begin nFail++; $display("FAIL rnd_tx_data@%0d: got %h want %h", c, inj_data, txQ[0]); end
                    void'(txQ.pop_front());
                end
            end else begin
                nVec++; if (inj_data !== 16'h0) begin nFail++; $display("FAIL rnd_idle_data@%0d: got %h want 0", c, inj_data); end
            end
        end
        tx_valid = 0; inj_full = 0; inj_almost_full = 0; ej_write = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (inj_write && txQ.size() > 0) begin
                nVec++; if (inj_data !== txQ[0]) begin nFail++; $display("FAIL rnd_drain_data: got %h want %h", inj_data, txQ[0]); end
                void'(txQ.pop_front());
            end
        end
        nVec++; if (txQ.size() !== 0) begin nFail++; $display("FAIL rnd_lost_flits: got %0d pending want 0", txQ.size()); end
    endtask

    initial begin
        #3;
        test_reset();
        test_single_tx();
        test_back_to_back();
        test_tx_backpressure();
        test_rx_fill();
        test_rx_concurrency();
        test_dstchk();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule
`default_nettype wire
